prover_msg_tx: RTL and testbench

Prover-side transmitter for the verifier interface. It latches one prover result (computation id, result type, layer, round, coefficient vector and optional precomputation vector) and serializes it as a header word plus element words on a valid/ready stream toward the verifier. It then waits for the verifier's update (acknowledge) and re-sends on a negative acknowledge. It sits between the prover's sumcheck/output logic and the link that feeds the verifier's poll/update path.

---
 rtl/prover_msg_tx.sv | 197 +++++++++++++++++++
 tb/tb_prover_msg_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prover_msg_tx.sv
// Prover-side result transmitter: header + element words on a valid/ready
// stream, then waits for the verifier ack and re-sends on a nack.
module prover_msg_tx #(
    parameter int ELMWIDTH  = 61,
    parameter int NELMS     = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      send_en,
    input  logic [31:0]               comp_id,
    input  logic [3:0]                result_type,
    input  logic [7:0]                layer,
    input  logic [7:0]                round,
    input  logic [4:0]                n_elms,
    input  logic                      has_precomp,
    input  logic [NELMS*ELMWIDTH-1:0] p_vec,
    input  logic [NELMS*ELMWIDTH-1:0] precomp_vec,
    output logic                      ready,
    output logic [63:0]               tx_data,
    output logic                      tx_valid,
    output logic                      tx_last,
    input  logic                      tx_ready,
    input  logic                      ack_valid,
    input  logic [31:0]               ack_id,
    input  logic                      ack_ok,
    output logic                      done,
    output logic                      fail
);

    localparam int VW = NELMS * ELMWIDTH;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PV,
        PC,
        WAIT_ACK
    } state_t;

    state_t          state;
    logic [31:0]     lat_id;
    logic [3:0]      lat_type;
    logic [7:0]      lat_layer;
    logic [7:0]      lat_round;
    logic [4:0]      lat_n;
    logic            lat_pc;
    logic [VW-1:0]   p_reg;
    logic [VW-1:0]   pc_reg;
    logic [4:0]      idx;
    logic [RW-1:0]   retry;

    logic [4:0]      n_clamp;
    logic [4:0]      last_idx;
    logic [4:0]      idx_nx;
    logic            ack_hit;

    function automatic logic [63:0] hdr_word(
        input logic [31:0] id,
        input logic [3:0]  t,
        input logic [7:0]  l,
        input logic [7:0]  r,
        input logic [4:0]  n,
        input logic        pc
    );
        return {id, t, l, r, n, pc, 6'b0};
    endfunction

    function automatic logic [63:0] elm_word(
        input logic [VW-1:0] v,
        input logic [4:0]    i
    );
        logic [63:0] w;
        w = '0;
        w[ELMWIDTH-1:0] = v[int'(i)*ELMWIDTH +: ELMWIDTH];
        return w;
    endfunction

    assign n_clamp  = (int'(n_elms) > NELMS) ? 5'(NELMS) : n_elms;
    assign last_idx = lat_n - 5'd1;
    assign idx_nx   = idx + 5'd1;
    assign ack_hit  = ack_valid && (ack_id == lat_id);
    assign ready    = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_data  <= '0;
            done     <= 1'b0;
            fail     <= 1'b0;
            retry    <= '0;
            idx      <= '0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (send_en) begin
                        lat_id    <= comp_id;
                        lat_type  <= result_type;
                        lat_layer <= layer;
                        lat_round <= round;
                        lat_n     <= n_clamp;
                        lat_pc    <= has_precomp;
                        p_reg     <= p_vec;
                        pc_reg    <= precomp_vec;
                        retry     <= '0;
                        idx       <= '0;
                        tx_data   <= hdr_word(comp_id, result_type, layer,
                                              round, n_clamp, has_precomp);
                        tx_valid  <= 1'b1;
                        tx_last   <= (n_clamp == 5'd0);
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (tx_ready) begin
                        if (lat_n == 5'd0) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            tx_data  <= '0;
                            state    <= WAIT_ACK;
                        end else begin
                            idx     <= '0;
                            tx_data <= elm_word(p_reg, 5'd0);
                            tx_last <= !lat_pc && (lat_n == 5'd1);
                            state   <= PV;
                        end
                    end
                end
                PV: begin
                    if (tx_ready) begin
                        if (idx == last_idx) begin
                            if (lat_pc) begin
                                idx     <= '0;
                                tx_data <= elm_word(pc_reg, 5'd0);
                                tx_last <= (lat_n == 5'd1);
                                state   <= PC;
                            end else begin
                                tx_valid <= 1'b0;
                                tx_last  <= 1'b0;
                                tx_data  <= '0;
                                state    <= WAIT_ACK;
                            end
                        end else begin
                            idx     <= idx_nx;
                            tx_data <= elm_word(p_reg, idx_nx);
                            tx_last <= !lat_pc && (idx_nx == last_idx);
                        end
                    end
                end
                PC: begin
                    if (tx_ready) begin
                        if (idx == last_idx) begin
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                            tx_data  <= '0;
                            state    <= WAIT_ACK;
                        end else begin
                            idx     <= idx_nx;
                            tx_data <= elm_word(pc_reg, idx_nx);
                            tx_last <= (idx_nx == last_idx);
                        end
                    end
                end
                WAIT_ACK: begin
                    if (ack_hit) begin
                        if (ack_ok) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else if (retry < RW'(MAX_RETRY)) begin
                            // replay from the latched copy, not the live inputs
                            retry    <= retry + RW'(1);
                            idx      <= '0;
                            tx_data  <= hdr_word(lat_id, lat_type, lat_layer,
                                                 lat_round, lat_n, lat_pc);
                            tx_valid <= 1'b1;
                            tx_last  <= (lat_n == 5'd0);
                            state    <= HDR;
                        end else begin
                            fail  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prover_msg_tx.sv
// Directed bench for prover_msg_tx: header/element serialization,
// backpressure, retry/fail, ack filtering and mid-message reset.
module tb_prover_msg_tx;

    localparam int EW = 61;
    localparam int NE = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              send_en;
    logic [31:0]       comp_id;
    logic [3:0]        result_type;
    logic [7:0]        layer;
    logic [7:0]        round;
    logic [4:0]        n_elms;
    logic              has_precomp;
    logic [NE*EW-1:0]  p_vec;
    logic [NE*EW-1:0]  precomp_vec;
    logic              ready;
    logic [63:0]       tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_ready;
    logic              ack_valid;
    logic [31:0]       ack_id;
    logic              ack_ok;
    logic              done;
    logic              fail;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] got_w[64];
    logic        got_l[64];
    int          got_n;
    logic [63:0] exp_w[64];
    int          exp_n;

    always #5 clk = ~clk;

    prover_msg_tx dut (
        .clk(clk), .rst(rst), .send_en(send_en), .comp_id(comp_id),
        .result_type(result_type), .layer(layer), .round(round),
        .n_elms(n_elms), .has_precomp(has_precomp), .p_vec(p_vec),
        .precomp_vec(precomp_vec), .ready(ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .ack_valid(ack_valid), .ack_id(ack_id), .ack_ok(ack_ok),
        .done(done), .fail(fail)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] id, input logic [3:0] t,
                        input logic [7:0] l, input logic [7:0] r,
                        input logic [4:0] n, input logic pc);
        comp_id = id; result_type = t; layer = l; round = r;
        n_elms = n; has_precomp = pc; send_en = 1'b1;
        @(negedge clk);
        send_en = 1'b0;
    endtask

    task automatic do_ack(input logic [31:0] id, input logic ok);
        ack_valid = 1'b1; ack_id = id; ack_ok = ok;
        @(negedge clk);
        ack_valid = 1'b0;
    endtask

    // mode 0: tx_ready high; mode 1: 1,0,0,1 pattern. ack_at injects an
    // ok-ack for id 7 at that cycle while the stream is running.
    task automatic collect(input int mode, input int ack_at);
        logic        stall;
        logic [63:0] sd;
        logic        sl;
        logic        fin;
        stall = 1'b0; sd = '0; sl = 1'b0; fin = 1'b0;
        got_n = 0;
        for (int k = 0; k < 200; k++) begin
            tx_ready  = (mode == 0) || (k % 4 == 0) || (k % 4 == 3);
            ack_valid = (k == ack_at);
            ack_id    = 32'd7;
            ack_ok    = 1'b1;
            if (stall) begin
                chk("stall_data", tx_data, sd);
                chk("stall_valid", 64'(tx_valid), 64'd1);
                chk("stall_last", 64'(tx_last), 64'(sl));
            end
            if (tx_valid && tx_ready && got_n < 64) begin
                got_w[got_n] = tx_data;
                got_l[got_n] = tx_last;
                got_n++;
                fin = tx_last;
            end
            stall = tx_valid && !tx_ready;
            sd = tx_data;
            sl = tx_last;
            @(negedge clk);
            if (fin) break;
        end
        ack_valid = 1'b0;
        tx_ready  = 1'b1;
        chk("collect_end_seen", 64'(fin), 64'd1);
        chk("valid_low_after_last", 64'(tx_valid), 64'd0);
    endtask

    task automatic check_msg(input string tag);
        chk({tag, "_count"}, 64'(got_n), 64'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
            chk($sformatf("%s_l%0d", tag, i), 64'(got_l[i]),
                64'(i == exp_n - 1));
        end
    endtask

    initial begin
        rst = 1'b1; send_en = 1'b1; comp_id = 32'd7; result_type = 4'd2;
        layer = 8'd3; round = 8'd5; n_elms = 5'd2; has_precomp = 1'b1;
        p_vec = '0; precomp_vec = '0; tx_ready = 1'b1;
        ack_valid = 1'b0; ack_id = '0; ack_ok = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_last", 64'(tx_last), 64'd0);
        chk("rst_data", tx_data, 64'd0);
        chk("rst_done_fail", {62'd0, done, fail}, 64'd0);
        send_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 64'(ready), 64'd1);

        // basic send, with an ack injected mid-PV that must be ignored
        p_vec[0*EW +: EW] = 61'h11;
        p_vec[1*EW +: EW] = 61'h22;
        p_vec[2*EW +: EW] = 61'h77;
        precomp_vec[0*EW +: EW] = 61'h33;
        precomp_vec[1*EW +: EW] = 61'h44;
        send(32'd7, 4'd2, 8'd3, 8'd5, 5'd2, 1'b1);
        chk("basic_hdr_valid", 64'(tx_valid), 64'd1);
        chk("basic_busy", 64'(ready), 64'd0);
        exp_n = 5;
        exp_w[0] = 64'h0000_0007_2030_5140;
        exp_w[1] = 64'h11; exp_w[2] = 64'h22;
        exp_w[3] = 64'h33; exp_w[4] = 64'h44;
        collect(0, 2);
        check_msg("basic");
        send_en = 1'b1; comp_id = 32'h99;
        @(negedge clk);
        send_en = 1'b0;
        chk("wait_ready_low", 64'(ready), 64'd0);
        do_ack(32'd9, 1'b1);
        chk("wrong_id_done", 64'(done), 64'd0);
        chk("wrong_id_ready", 64'(ready), 64'd0);
        do_ack(32'd7, 1'b1);
        chk("basic_done", 64'(done), 64'd1);
        chk("basic_ready", 64'(ready), 64'd1);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("busy_send_not_queued", 64'(tx_valid), 64'd0);

        // backpressure on the same message
        send(32'd7, 4'd2, 8'd3, 8'd5, 5'd2, 1'b1);
        collect(1, -1);
        check_msg("bp");
        do_ack(32'd7, 1'b1);
        chk("bp_done", 64'(done), 64'd1);

        // zero elements: header alone carries tx_last
        send(32'h0A, 4'd1, 8'd0, 8'd0, 5'd0, 1'b0);
        exp_n = 1;
        exp_w[0] = 64'h0000_000A_1000_0000;
        collect(0, -1);
        check_msg("zero");
        @(negedge clk);
        chk("zero_waiting", 64'(ready), 64'd0);
        do_ack(32'h0A, 1'b1);
        chk("zero_done", 64'(done), 64'd1);

        // n_elms above NELMS clamps to 16; element 0 checks zero-extension
        p_vec[0*EW +: EW] = {EW{1'b1}};
        for (int i = 1; i < NE; i++) p_vec[i*EW +: EW] = 61'(i * 257);
        send(32'h55, 4'd0, 8'd0, 8'd0, 5'd20, 1'b0);
        exp_n = 17;
        exp_w[0] = 64'h0000_0055_0000_0800;
        exp_w[1] = 64'h1FFF_FFFF_FFFF_FFFF;
        for (int i = 1; i < NE; i++) exp_w[1+i] = 64'(i * 257);
        collect(0, -1);
        check_msg("clamp");
        do_ack(32'h55, 1'b1);
        chk("clamp_done", 64'(done), 64'd1);

        // three nacks then ok; live inputs change after latching
        p_vec[0*EW +: EW] = 61'h99;
        send(32'd7, 4'd2, 8'd3, 8'd5, 5'd1, 1'b0);
        comp_id = 32'hDEAD; p_vec = '1; n_elms = 5'd3;
        exp_n = 2;
        exp_w[0] = 64'h0000_0007_2030_5080;
        exp_w[1] = 64'h99;
        collect(0, -1);
        check_msg("retry_first");
        for (int r = 0; r < 3; r++) begin
            do_ack(32'd7, 1'b0);
            chk($sformatf("resend%0d_valid", r), 64'(tx_valid), 64'd1);
            chk($sformatf("resend%0d_hdr", r), tx_data, exp_w[0]);
            collect(0, -1);
            check_msg($sformatf("resend%0d", r));
        end
        do_ack(32'd7, 1'b1);
        chk("retry_done", 64'(done), 64'd1);
        chk("retry_no_fail", 64'(fail), 64'd0);

        // four nacks: fail, no fourth re-send
        p_vec[0*EW +: EW] = 61'h99;
        send(32'd7, 4'd2, 8'd3, 8'd5, 5'd1, 1'b0);
        collect(0, -1);
        for (int r = 0; r < 3; r++) begin
            do_ack(32'd7, 1'b0);
            collect(0, -1);
            check_msg($sformatf("failpath%0d", r));
        end
        do_ack(32'd7, 1'b0);
        chk("fail_pulse", 64'(fail), 64'd1);
        chk("fail_no_done", 64'(done), 64'd0);
        chk("fail_no_resend", 64'(tx_valid), 64'd0);
        chk("fail_ready", 64'(ready), 64'd1);
        @(negedge clk);
        chk("fail_one_cycle", 64'(fail), 64'd0);
        chk("fail_still_idle", 64'(tx_valid), 64'd0);

        // reset during the second element word
        p_vec[0*EW +: EW] = 61'h11;
        p_vec[1*EW +: EW] = 61'h22;
        send(32'd7, 4'd2, 8'd3, 8'd5, 5'd2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_word", tx_data, 64'h22);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", 64'(tx_valid), 64'd0);
        chk("rst_mid_ready", 64'(ready), 64'd1);
        chk("rst_mid_pulses", {62'd0, done, fail}, 64'd0);
        @(negedge clk);
        chk("post_rst_pulses", {62'd0, done, fail}, 64'd0);
        send(32'd7, 4'd2, 8'd3, 8'd5, 5'd0, 1'b0);
        chk("post_rst_hdr", tx_data, 64'h0000_0007_2030_5000);
        exp_n = 1;
        exp_w[0] = 64'h0000_0007_2030_5000;
        collect(0, -1);
        check_msg("post_rst");
        do_ack(32'd7, 1'b1);
        chk("post_rst_done", 64'(done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
